// File: rtl/nibble_scan_display.sv
// Four-deep nibble history captured on push edges, scanned out
// as hex glyphs on a common-anode 4-digit 7-segment display.
module nibble_scan_display #(
  parameter int CLK_DIV = 10000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] nibble_i,
  input  logic       push_i,
  input  logic       clear_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic [2:0] count_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic            push_q;
  logic [3:0][3:0] buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            cap;
  logic            wrap;

  function automatic logic [6:0] hex(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    cap   = push_i & ~push_q;
    wrap  = (div_q == DIV_MAX);
    buf_d = buf_q;
    cnt_d = cnt_q;
    // clear wins over a simultaneous capture
    if (clear_i) begin
      buf_d = '0;
      cnt_d = 3'd0;
    end else if (cap) begin
      buf_d = {buf_q[2:0], nibble_i};
      if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
    end
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if ({1'b0, idx_q} < cnt_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex(buf_q[idx_q]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      push_q <= 1'b0;
      buf_q  <= '0;
      cnt_q  <= 3'd0;
      div_q  <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
    end else begin
      push_q <= push_i;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_nibble_scan_display.sv
// Bench for nibble_scan_display: cycle model of history/scan
// compared every cycle, plus directed literal checks.
module tb_nibble_scan_display;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       push = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] nib = 4'h0;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic [2:0] count_o;

  nibble_scan_display #(.CLK_DIV(D)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .nibble_i(nib),
    .push_i(push),
    .clear_i(clear),
    .an_o(an_o),
    .seg_o(seg_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  logic [6:0] gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  // model: history list newest-first, scan slot from edge count
  logic [3:0] mh [4];
  int         mcnt;
  int         mk;
  int         mid;
  bit         mpq;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  bit         seen21;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) mh[i] = 4'h0;
      mcnt  = 0;
      mk    = 0;
      mpq   = 0;
      m_an  = 4'b1111;
      m_seg = 7'h7F;
    end else begin
      mid = (mk / D) % 4;
      if (mid < mcnt) begin
        m_an  = ~(4'b0001 << mid);
        m_seg = gly[mh[mid]];
      end else begin
        m_an  = 4'b1111;
        m_seg = 7'h7F;
      end
      if (clear) begin
        for (int i = 0; i < 4; i++) mh[i] = 4'h0;
        mcnt = 0;
      end else if (push && !mpq) begin
        for (int i = 3; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = nib;
        if (mcnt < 4) mcnt++;
      end
      mpq = push;
      mk++;
    end
  end

  always @(negedge clk) begin
    chk("an", an_o, m_an);
    chk("seg", seg_o, m_seg);
    chk("cnt", count_o, mcnt);
    if (seg_o == 7'h21) seen21 = 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cap(input logic [3:0] v);
    nib  = v;
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    nib  = 4'($urandom);
    @(negedge clk);
  endtask

  task automatic clr();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v, input string n);
    int k = 0;
    while (an_o !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(n, an_o, v);
  endtask

  logic [3:0] exp_an4 [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_sg4 [4] = '{7'h46, 7'h78, 7'h24, 7'h79};
  logic [3:0] rec_an [16];
  logic [6:0] rec_sg [16];

  initial begin
    int c0;
    int cb;
    cyc(3);
    chk("rst_an", an_o, 4'b1111);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_cnt", count_o, 3'd0);
    rstn = 1'b1;
    cyc(32);
    chk("idle_an", an_o, 4'b1111);

    cap(4'h4);
    chk("s2_cnt", count_o, 3'd1);
    wait_an(4'b1110, "s2_dig0");
    chk("s2_seg", seg_o, 7'h19);
    c0 = 0;
    cb = 0;
    for (int i = 0; i < 16; i++) begin
      if (an_o == 4'b1110) c0++;
      else if (an_o == 4'b1111) cb++;
      @(negedge clk);
    end
    chk("s2_lit", c0, 4);
    chk("s2_blank", cb, 12);

    clr();
    nib  = 4'hA;
    push = 1'b1;
    cyc(10);
    push = 1'b0;
    cyc(1);
    chk("s3_cnt", count_o, 3'd1);
    wait_an(4'b1110, "s3_dig0");
    chk("s3_seg", seg_o, 7'h08);

    clr();
    cap(4'h0);
    cap(4'h1);
    cap(4'h2);
    cap(4'h7);
    cap(4'hC);
    chk("s4_cnt", count_o, 3'd4);
    wait_an(4'b0111, "s4_dig3");
    wait_an(4'b1110, "s4_dig0");
    for (int i = 0; i < 16; i++) begin
      rec_an[i] = an_o;
      rec_sg[i] = seg_o;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s4_an%0d", i), rec_an[i], exp_an4[i/4]);
      chk($sformatf("s4_sg%0d", i), rec_sg[i], exp_sg4[i/4]);
    end

    clr();
    cap(4'h1);
    cap(4'h2);
    cap(4'h3);
    chk("s5_cnt3", count_o, 3'd3);
    seen21 = 0;
    clear  = 1'b1;
    push   = 1'b1;
    nib    = 4'hD;
    @(negedge clk);
    chk("s5_cnt0", count_o, 3'd0);
    clear = 1'b0;
    @(negedge clk);
    chk("s5_blank", an_o, 4'b1111);
    cyc(5);
    push = 1'b0;
    cyc(20);
    chk("s5_cnt_end", count_o, 3'd0);
    chk("s5_no_d", seen21, 1'b0);

    cap(4'h1);
    cap(4'h2);
    cap(4'h3);
    cap(4'h4);
    wait_an(4'b1011, "s6_dig2");
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("s6_an", an_o, 4'b1111);
    chk("s6_seg", seg_o, 7'h7F);
    chk("s6_cnt", count_o, 3'd0);
    @(negedge clk);
    cyc(2);
    rstn = 1'b1;
    push = 1'b1;
    nib  = 4'h5;
    @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    chk("s6_idx0_an", an_o, 4'b1110);
    chk("s6_idx0_seg", seg_o, 7'h12);
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_scan_display.md
# nibble_scan_display

Downstream consumer of the 3-to-4 code decoder. Captures the 4-bit decoder output `y` into a 4-entry history buffer on each rising edge of a push strobe. It then time-multiplexes the captured nibbles onto a 4-digit common-anode 7-segment display as hex glyphs. It sits between the decoder and the board's `an`/`seg` pins.

## Interface

- `CLK_DIV`, default 10000: clock cycles each digit stays selected. Legal range is ≥ 1.
- `clk_i`, in, 1: system clock. All state changes on its rising edge.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `nibble_i`, in, 4: value to capture; connected to decoder `y`.
- `push_i`, in, 1: capture strobe. Synchronous to `clk_i`, level input; a capture happens only on its rising edge.
- `clear_i`, in, 1: synchronous clear of the history buffer.
- `an_o`, out, 4: digit enables, active-low. `an_o[k]` selects digit k.
- `seg_o`, out, 7: segments, active-low, ordered `{g,f,e,d,c,b,a}` (`seg_o[0]` = a).
- `count_o`, out, 3: number of valid entries, 0..4.

## Operation

- **Edge detect:** register `push_q <= push_i`. A capture event is `push_i & ~push_q`.
  - Holding `push_i` high captures exactly once.
- **Capture:** `buf[3] <= buf[2]`, `buf[2] <= buf[1]`, `buf[1] <= buf[0]`, `buf[0] <= nibble_i`.
  - Newest entry is always digit 0.
  - `count_o` increments and saturates at 4.
  - When full, the oldest entry (`buf[3]`) is dropped.
- **Clear:** when `clear_i` = 1, all `buf` entries go to 0 and `count_o` goes to 0.
  - If clear and a capture event occur in the same cycle, clear wins and the capture is discarded.
  - `push_q` still updates, so a held push does not re-capture after clear.
- **Prescaler:** `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - On wrap, the scan index `idx` (2 bits) increments modulo 4.
  - With `CLK_DIV` = 1, `idx` advances every cycle.
- **Digit drive:** registered outputs.
  - If `idx < count_o`: `an_o <= ~(4'b0001 << idx)` and `seg_o <= hex(buf[idx])`.
  - Otherwise the digit is blank: `an_o <= 4'b1111`, `seg_o <= 7'h7F`.
- **Glyphs:** `hex()` uses standard glyphs (6 with top bar a, 7 without f, 9 with d, lower-case b and d).
  - Required values: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 4 = 7'h19, 7 = 7'h78, A = 7'h08, C = 7'h46, d = 7'h21.
- **Buffer width:** entries are 4 bits. `count_o` is 3 bits and never exceeds 4.
- **Reset values:**
  - `buf` entries = 0, `count_o` = 0, `push_q` = 0, `div_cnt` = 0, `idx` = 0.
  - `an_o` = 4'b1111, `seg_o` = 7'h7F.

## Timing

- A capture edge sampled at clock edge N updates `buf`/`count_o` at edge N. `count_o` is visible immediately after edge N.
- `an_o`/`seg_o` reflect the new buffer contents from edge N+1 (one cycle of display latency).
- `idx` changes on the edge where `div_cnt` wraps. `an_o`/`seg_o` follow one edge later.
  - Each digit is driven for exactly `CLK_DIV` cycles.
  - A full scan takes 4·`CLK_DIV` cycles.
- Asserting `rstn_i` mid-scan or mid-capture forces all reset values immediately, without waiting for a clock. The first capture after release requires a fresh `push_i` rising edge.
- `clear_i` takes effect at the next edge. The display blanks all digits one edge later.
- `nibble_i` is sampled only in the capture cycle; changes at other times have no effect.

## Test plan

All scenarios use `CLK_DIV` = 4.

1. **Reset:** hold `rstn_i` = 0 → `an_o` = 4'b1111, `seg_o` = 7'h7F, `count_o` = 0. After release with no push, the display stays blank for 32 cycles.
2. **Single capture:** `nibble_i` = 4'h4, pulse `push_i` for 1 cycle → `count_o` = 1.
   - While `idx` = 0: `an_o` = 4'b1110, `seg_o` = 7'h19.
   - For `idx` = 1..3: `an_o` = 4'b1111.
3. **Held push:** `nibble_i` = 4'hA with `push_i` high for 10 cycles → exactly one capture, `count_o` = 1.
4. **Overflow:** capture 0, 1, 2, 7, then C → `count_o` = 4 and `buf` = {C, 7, 2, 1} for digits 0..3. The value 0 is dropped.
   - Over one 16-cycle scan, `seg_o` shows 7'h46, 7'h78, 7'h24, 7'h79.
   - The corresponding `an_o` sequence is 1110, 1101, 1011, 0111.
5. **Clear vs capture:** with 3 entries, assert `clear_i` in the same cycle as a push rising edge (`nibble_i` = 4'hD) → `count_o` = 0 and all digits blank next cycle. No glyph 7'h21 ever appears.
6. **Mid-scan reset:** assert `rstn_i` = 0 asynchronously while `idx` = 2 and `count_o` = 4 → outputs go to reset values before the next clock edge. After release, `idx` restarts at 0.
